// File: rtl/mips_pkg.sv
// Shared MIPS32 decode constants: opcode/funct fields, EX aluop and alusel
// codes, and the ID/EX occupancy state type.
package mips_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    // EX operation codes
    localparam logic [7:0] EXE_NOP_OP   = 8'h00;
    localparam logic [7:0] EXE_SRL_OP   = 8'h02;
    localparam logic [7:0] EXE_SRA_OP   = 8'h03;
    localparam logic [7:0] EXE_ADDU_OP  = 8'h21;
    localparam logic [7:0] EXE_SUBU_OP  = 8'h23;
    localparam logic [7:0] EXE_AND_OP   = 8'h24;
    localparam logic [7:0] EXE_OR_OP    = 8'h25;
    localparam logic [7:0] EXE_XOR_OP   = 8'h26;
    localparam logic [7:0] EXE_NOR_OP   = 8'h27;
    localparam logic [7:0] EXE_ADDIU_OP = 8'h56;
    localparam logic [7:0] EXE_SLL_OP   = 8'h7C;

    // EX result selectors
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    localparam logic [4:0]  NOPRegAddr = 5'b00000;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    typedef logic [7:0] aluop_t;
    typedef logic [2:0] alusel_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } id_state_e;

endpackage

// File: rtl/id_decoder.sv
// Combinational MIPS32 instruction decoder. Unrecognised opcodes/functs come
// out as a NOP with invalid=1, no register reads and no write-back.
// Shift instructions carry shamt on operand 1 (imm1); immediates use imm2.
module id_decoder
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [31:0]       inst,
    output aluop_t            aluop,
    output alusel_t           alusel,
    output logic [REG_AW-1:0] waddr,
    output logic              wr_en,
    output logic [DATA_W-1:0] imm1,
    output logic [DATA_W-1:0] imm2,
    output logic              rd_en1,
    output logic              rd_en2,
    output logic              invalid
);

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] zimm;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] uimm;
    logic [DATA_W-1:0] shamt;

    assign op    = inst[31:26];
    assign funct = inst[5:0];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign zimm  = {{(DATA_W-16){1'b0}}, inst[15:0]};
    assign simm  = {{(DATA_W-16){inst[15]}}, inst[15:0]};
    assign uimm  = {inst[15:0], {(DATA_W-16){1'b0}}};
    assign shamt = {{(DATA_W-5){1'b0}}, inst[10:6]};

    // Decode opcode/funct into EX controls and operand sources
    always_comb begin
        aluop   = EXE_NOP_OP;
        alusel  = EXE_RES_NOP;
        waddr   = NOPRegAddr;
        wr_en   = 1'b0;
        imm1    = '0;
        imm2    = '0;
        rd_en1  = 1'b0;
        rd_en2  = 1'b0;
        invalid = 1'b0;
        case (op)
            OP_SPECIAL: begin
                waddr  = rd;
                wr_en  = 1'b1;
                rd_en1 = 1'b1;
                rd_en2 = 1'b1;
                case (funct)
                    FN_AND:  begin aluop = EXE_AND_OP;  alusel = EXE_RES_LOGIC; end
                    FN_OR:   begin aluop = EXE_OR_OP;   alusel = EXE_RES_LOGIC; end
                    FN_XOR:  begin aluop = EXE_XOR_OP;  alusel = EXE_RES_LOGIC; end
                    FN_NOR:  begin aluop = EXE_NOR_OP;  alusel = EXE_RES_LOGIC; end
                    FN_ADDU: begin aluop = EXE_ADDU_OP; alusel = EXE_RES_ARITH; end
                    FN_SUBU: begin aluop = EXE_SUBU_OP; alusel = EXE_RES_ARITH; end
                    FN_SLL:  begin aluop = EXE_SLL_OP; alusel = EXE_RES_SHIFT; rd_en1 = 1'b0; imm1 = shamt; end
                    FN_SRL:  begin aluop = EXE_SRL_OP; alusel = EXE_RES_SHIFT; rd_en1 = 1'b0; imm1 = shamt; end
                    FN_SRA:  begin aluop = EXE_SRA_OP; alusel = EXE_RES_SHIFT; rd_en1 = 1'b0; imm1 = shamt; end
                    default: begin
                        waddr   = NOPRegAddr;
                        wr_en   = 1'b0;
                        rd_en1  = 1'b0;
                        rd_en2  = 1'b0;
                        invalid = 1'b1;
                    end
                endcase
            end
            OP_ORI:   begin aluop = EXE_OR_OP;    alusel = EXE_RES_LOGIC; waddr = rt; wr_en = 1'b1; rd_en1 = 1'b1; imm2 = zimm; end
            OP_ANDI:  begin aluop = EXE_AND_OP;   alusel = EXE_RES_LOGIC; waddr = rt; wr_en = 1'b1; rd_en1 = 1'b1; imm2 = zimm; end
            OP_XORI:  begin aluop = EXE_XOR_OP;   alusel = EXE_RES_LOGIC; waddr = rt; wr_en = 1'b1; rd_en1 = 1'b1; imm2 = zimm; end
            OP_ADDIU: begin aluop = EXE_ADDIU_OP; alusel = EXE_RES_ARITH; waddr = rt; wr_en = 1'b1; rd_en1 = 1'b1; imm2 = simm; end
            // LUI ignores rs so the result is exactly imm<<16 whatever rs holds
            OP_LUI:   begin aluop = EXE_OR_OP;    alusel = EXE_RES_LOGIC; waddr = rt; wr_en = 1'b1; imm2 = uimm; end
            default:  invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS32 decode stage with a valid/ready ID/EX register.
// Build option: ID_FWD_EN -- when defined, operands are forwarded from EX/MEM
// and only load-use stalls; when undefined, operands come from the regfile
// only and any pending EX/MEM write to a source register stalls.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | ID/EX register holds nothing (ex_valid=0)
// ST_FULL  | ID/EX register holds an instruction for EX
module id_stage_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [DATA_W-1:0]   id_pc,
    input  logic [31:0]         id_inst,
    output logic                reg1_rd_en,
    output logic                reg2_rd_en,
    output logic [REG_AW-1:0]   reg1_addr,
    output logic [REG_AW-1:0]   reg2_addr,
    input  logic [DATA_W-1:0]   reg1_data,
    input  logic [DATA_W-1:0]   reg2_data,
    input  logic                ex_fw_wr_en,
    input  logic [REG_AW-1:0]   ex_fw_waddr,
    input  logic [DATA_W-1:0]   ex_fw_wdata,
    input  logic                ex_fw_is_load,
    input  logic                mem_fw_wr_en,
    input  logic [REG_AW-1:0]   mem_fw_waddr,
    input  logic [DATA_W-1:0]   mem_fw_wdata,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [DATA_W-1:0]   ex_pc,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_reg1,
    output logic [DATA_W-1:0]   ex_reg2,
    output logic [REG_AW-1:0]   ex_waddr,
    output logic                ex_wr_en,
    output logic                ex_inst_invalid,
    output logic [CNT_W-1:0]    stall_cnt
);

    aluop_t            dec_aluop;
    alusel_t           dec_alusel;
    logic [REG_AW-1:0] dec_waddr;
    logic              dec_wr_en;
    logic [DATA_W-1:0] dec_imm1;
    logic [DATA_W-1:0] dec_imm2;
    logic              dec_rd_en1;
    logic              dec_rd_en2;
    logic              dec_invalid;

    id_decoder #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_dec (
        .inst    (id_inst),
        .aluop   (dec_aluop),
        .alusel  (dec_alusel),
        .waddr   (dec_waddr),
        .wr_en   (dec_wr_en),
        .imm1    (dec_imm1),
        .imm2    (dec_imm2),
        .rd_en1  (dec_rd_en1),
        .rd_en2  (dec_rd_en2),
        .invalid (dec_invalid)
    );

    assign reg1_addr  = id_inst[25:21];
    assign reg2_addr  = id_inst[20:16];
    assign reg1_rd_en = dec_rd_en1;
    assign reg2_rd_en = dec_rd_en2;

    // A pending write only matters for an enabled, non-$0 source register
    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, load_use, hazard;
    assign ex_hit1  = dec_rd_en1 && ex_fw_wr_en  && (ex_fw_waddr  != '0) && (ex_fw_waddr  == reg1_addr);
    assign ex_hit2  = dec_rd_en2 && ex_fw_wr_en  && (ex_fw_waddr  != '0) && (ex_fw_waddr  == reg2_addr);
    assign mem_hit1 = dec_rd_en1 && mem_fw_wr_en && (mem_fw_waddr != '0) && (mem_fw_waddr == reg1_addr);
    assign mem_hit2 = dec_rd_en2 && mem_fw_wr_en && (mem_fw_waddr != '0) && (mem_fw_waddr == reg2_addr);
    assign load_use = ex_fw_is_load && (ex_hit1 || ex_hit2);

    logic [DATA_W-1:0] op1, op2;

`ifdef ID_FWD_EN
    assign hazard = load_use;

    // Operand select: immediate, $0, then EX forward over MEM forward over regfile
    always_comb begin
        op1 = reg1_data;
        op2 = reg2_data;
        if (!dec_rd_en1)         op1 = dec_imm1;
        else if (reg1_addr == '0) op1 = ZeroWord;
        else if (ex_hit1)         op1 = ex_fw_wdata;
        else if (mem_hit1)        op1 = mem_fw_wdata;
        if (!dec_rd_en2)         op2 = dec_imm2;
        else if (reg2_addr == '0) op2 = ZeroWord;
        else if (ex_hit2)         op2 = ex_fw_wdata;
        else if (mem_hit2)        op2 = mem_fw_wdata;
    end
`else
    // No forwarding paths: wait until neither EX nor MEM will write a source
    assign hazard = load_use || ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;

    logic unused_fwd_data;
    assign unused_fwd_data = ^{ex_fw_wdata, mem_fw_wdata};

    // Operand select: immediate, $0, then regfile
    always_comb begin
        op1 = reg1_data;
        op2 = reg2_data;
        if (!dec_rd_en1)         op1 = dec_imm1;
        else if (reg1_addr == '0) op1 = ZeroWord;
        if (!dec_rd_en2)         op2 = dec_imm2;
        else if (reg2_addr == '0) op2 = ZeroWord;
    end
`endif

    id_state_e state;
    logic      accept;

    assign ex_valid = (state == ST_FULL);
    assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
    assign accept   = if_valid && if_ready;

    // ID/EX register: load on accept, drain on ex_ready/flush/bubble, else hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_EMPTY;
            ex_pc           <= '0;
            ex_aluop        <= EXE_NOP_OP;
            ex_alusel       <= EXE_RES_NOP;
            ex_reg1         <= ZeroWord;
            ex_reg2         <= ZeroWord;
            ex_waddr        <= '0;
            ex_wr_en        <= 1'b0;
            ex_inst_invalid <= 1'b0;
        end else if (accept) begin
            state           <= ST_FULL;
            ex_pc           <= id_pc;
            ex_aluop        <= dec_aluop;
            ex_alusel       <= dec_alusel;
            ex_reg1         <= op1;
            ex_reg2         <= op2;
            ex_waddr        <= dec_waddr;
            ex_wr_en        <= dec_wr_en;
            ex_inst_invalid <= dec_invalid;
        end else if (flush || !ex_valid || ex_ready) begin
            state <= ST_EMPTY;
        end
    end

    // Saturating count of stalled fetch cycles; flush cycles are excluded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (if_valid && hazard && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe. Expected ID/EX contents are queued when an
// instruction is presented and checked when EX takes it. Expectations
// follow ID_FWD_EN when the bench is built with that macro.
module tb_id_stage_pipe;

    localparam logic [7:0] A_NOP = 8'h00, A_OR = 8'h25, A_AND = 8'h24, A_XOR = 8'h26,
                           A_NOR = 8'h27, A_SUBU = 8'h23, A_ADDIU = 8'h56, A_SLL = 8'h7C;
    localparam logic [2:0] S_NOP = 3'b000, S_LOGIC = 3'b001, S_SHIFT = 3'b010, S_ARITH = 3'b100;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  waddr;
        logic        wr_en;
        logic        inv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, if_ready, ex_ready;
    logic [31:0] id_pc, id_inst;
    logic        reg1_rd_en, reg2_rd_en;
    logic [4:0]  reg1_addr, reg2_addr;
    logic [31:0] reg1_data, reg2_data;
    logic        ex_fw_wr_en, ex_fw_is_load, mem_fw_wr_en;
    logic [4:0]  ex_fw_waddr, mem_fw_waddr;
    logic [31:0] ex_fw_wdata, mem_fw_wdata;
    logic        ex_valid, ex_wr_en, ex_inst_invalid;
    logic [31:0] ex_pc, ex_reg1, ex_reg2;
    logic [7:0]  ex_aluop;
    logic [2:0]  ex_alusel;
    logic [4:0]  ex_waddr;
    logic [3:0]  stall_cnt;

    logic [31:0] rf [32];
    exp_t        sb [$];
    exp_t        mon_e, mon_got;
    int          vectors = 0;
    int          errors  = 0;
    int          exp_stall = 0;

    always #5 clk = ~clk;

    assign reg1_data = rf[reg1_addr];
    assign reg2_data = rf[reg2_addr];

    id_stage_pipe #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
        .id_pc(id_pc), .id_inst(id_inst),
        .reg1_rd_en(reg1_rd_en), .reg2_rd_en(reg2_rd_en),
        .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
        .reg1_data(reg1_data), .reg2_data(reg2_data),
        .ex_fw_wr_en(ex_fw_wr_en), .ex_fw_waddr(ex_fw_waddr), .ex_fw_wdata(ex_fw_wdata),
        .ex_fw_is_load(ex_fw_is_load),
        .mem_fw_wr_en(mem_fw_wr_en), .mem_fw_waddr(mem_fw_waddr), .mem_fw_wdata(mem_fw_wdata),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_aluop(ex_aluop),
        .ex_alusel(ex_alusel), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_waddr(ex_waddr),
        .ex_wr_en(ex_wr_en), .ex_inst_invalid(ex_inst_invalid), .stall_cnt(stall_cnt)
    );

    // EX consumes on negedge when valid & ready (a flush drops, not consumes)
    always @(negedge clk) begin
        if (rst && ex_valid && ex_ready && !flush) begin
            vectors++;
            mon_got = '{ex_pc, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_waddr, ex_wr_en, ex_inst_invalid};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: unexpected ex_valid, pc=%h", ex_pc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_got !== mon_e) begin
                    errors++;
                    $display("FAIL ex_out: got pc=%h op=%h sel=%b r1=%h r2=%h wa=%0d we=%b inv=%b, want pc=%h op=%h sel=%b r1=%h r2=%h wa=%0d we=%b inv=%b",
                             mon_got.pc, mon_got.aluop, mon_got.alusel, mon_got.r1, mon_got.r2, mon_got.waddr, mon_got.wr_en, mon_got.inv,
                             mon_e.pc, mon_e.aluop, mon_e.alusel, mon_e.r1, mon_e.r2, mon_e.waddr, mon_e.wr_en, mon_e.inv);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        flush = 0; if_valid = 0; ex_ready = 1; id_pc = '0; id_inst = '0;
        ex_fw_wr_en = 0; ex_fw_waddr = '0; ex_fw_wdata = '0; ex_fw_is_load = 0;
        mem_fw_wr_en = 0; mem_fw_waddr = '0; mem_fw_wdata = '0;
    endtask

    task automatic bump_stall;
        if (exp_stall < 15) exp_stall++;
    endtask

    task automatic test_reset;
        rst = 0;
        set_idle();
        #12;
        vectors++;
        if ({ex_valid, ex_aluop, ex_alusel, ex_wr_en, ex_inst_invalid} !== {1'b0, A_NOP, S_NOP, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b op=%h sel=%b we=%b inv=%b, want 0/00/000/0/0",
                     ex_valid, ex_aluop, ex_alusel, ex_wr_en, ex_inst_invalid);
        end
        vectors++;
        if ({ex_pc, ex_reg1, ex_reg2, ex_waddr, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_data: got pc=%h r1=%h r2=%h wa=%0d cnt=%0d, want all 0",
                     ex_pc, ex_reg1, ex_reg2, ex_waddr, stall_cnt);
        end
        @(negedge clk);
        rst = 1;
        tick();
    endtask

    task automatic test_ori;
        exp_t x;
        if_valid = 1; id_pc = 32'h100; id_inst = 32'h3401_1100;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL ori_if_ready: got %b want 1", if_ready); end
        x = '{32'h100, A_OR, S_LOGIC, 32'h0, 32'h0000_1100, 5'd1, 1'b1, 1'b0};
        sb.push_back(x);
        tick();
        if_valid = 0;
        vectors++;
        if (ex_valid !== 1'b1) begin errors++; $display("FAIL ori_ex_valid: got %b want 1", ex_valid); end
        tick();
    endtask

    task automatic test_forward;
        exp_t x;
        if_valid = 1; id_pc = 32'h110; id_inst = 32'h0023_1025;
        ex_fw_wr_en = 1; ex_fw_waddr = 5'd1; ex_fw_wdata = 32'h1234;
        mem_fw_wr_en = 1; mem_fw_waddr = 5'd1; mem_fw_wdata = 32'h5555;
        #1;
`ifdef ID_FWD_EN
        vectors++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL fwd_if_ready: got %b want 1", if_ready); end
        x = '{32'h110, A_OR, S_LOGIC, 32'h1234, 32'h0000_000F, 5'd2, 1'b1, 1'b0};
        sb.push_back(x);
        tick();
        ex_fw_wr_en = 0; id_pc = 32'h114;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL fwd_mem_if_ready: got %b want 1", if_ready); end
        x = '{32'h114, A_OR, S_LOGIC, 32'h5555, 32'h0000_000F, 5'd2, 1'b1, 1'b0};
        sb.push_back(x);
        tick();
`else
        vectors++;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL nofwd_stall_exmem: got if_ready=%b want 0", if_ready); end
        bump_stall();
        tick();
        vectors++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL nofwd_bubble: got ex_valid=%b want 0", ex_valid); end
        ex_fw_wr_en = 0;
        #1;
        vectors++;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL nofwd_stall_mem: got if_ready=%b want 0", if_ready); end
        bump_stall();
        tick();
        mem_fw_wr_en = 0;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL nofwd_release: got if_ready=%b want 1", if_ready); end
        x = '{32'h110, A_OR, S_LOGIC, 32'hAAAA_0001, 32'h0000_000F, 5'd2, 1'b1, 1'b0};
        sb.push_back(x);
        tick();
`endif
        vectors++;
        if (stall_cnt !== 4'(exp_stall)) begin errors++; $display("FAIL fwd_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
        set_idle();
        tick();
    endtask

    task automatic test_load_use;
        exp_t x;
        if_valid = 1; id_pc = 32'h120; id_inst = 32'h2424_FFFF;
        ex_fw_is_load = 1; ex_fw_wr_en = 1; ex_fw_waddr = 5'd1; ex_fw_wdata = 32'h9999;
        #1;
        vectors++;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL load_use_if_ready: got %b want 0", if_ready); end
        bump_stall();
        tick();
        vectors++;
        if ({ex_valid, stall_cnt} !== {1'b0, 4'(exp_stall)}) begin
            errors++;
            $display("FAIL load_use_bubble: got ex_valid=%b cnt=%0d want 0/%0d", ex_valid, stall_cnt, exp_stall);
        end
        ex_fw_is_load = 0; ex_fw_wr_en = 0;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL load_drop_if_ready: got %b want 1", if_ready); end
        x = '{32'h120, A_ADDIU, S_ARITH, 32'hAAAA_0001, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0};
        sb.push_back(x);
        tick();
        // a load into $0 never stalls
        id_pc = 32'h124; id_inst = 32'h3408_0001;
        ex_fw_is_load = 1; ex_fw_wr_en = 1; ex_fw_waddr = 5'd0;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL load_r0_if_ready: got %b want 1", if_ready); end
        x = '{32'h124, A_OR, S_LOGIC, 32'h0, 32'h1, 5'd8, 1'b1, 1'b0};
        sb.push_back(x);
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_backpressure;
        exp_t x;
        if_valid = 1; id_pc = 32'h200; id_inst = 32'h3805_00F0;
        x = '{32'h200, A_XOR, S_LOGIC, 32'h0, 32'h0000_00F0, 5'd5, 1'b1, 1'b0};
        sb.push_back(x);
        tick();
        ex_ready = 0; id_pc = 32'h204; id_inst = 32'h3007_FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({if_ready, ex_valid, ex_pc, ex_reg2, ex_waddr, ex_aluop} !== {1'b0, 1'b1, 32'h200, 32'hF0, 5'd5, A_XOR}) begin
                errors++;
                $display("FAIL hold_%0d: got rdy=%b vld=%b pc=%h r2=%h wa=%0d op=%h want 0/1/200/f0/5/26",
                         i, if_ready, ex_valid, ex_pc, ex_reg2, ex_waddr, ex_aluop);
            end
            tick();
        end
        ex_ready = 1;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got if_ready=%b want 1", if_ready); end
        x = '{32'h204, A_AND, S_LOGIC, 32'h0, 32'h0000_FFFF, 5'd7, 1'b1, 1'b0};
        sb.push_back(x);
        tick();
        if_valid = 0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] insts [4];
        exp_t        exps  [4];
        insts[0] = 32'h0003_4900; exps[0] = '{32'h300, A_SLL,  S_SHIFT, 32'h4,         32'h0000_000F, 5'd9,  1'b1, 1'b0};
        insts[1] = 32'h3C0A_ABCD; exps[1] = '{32'h304, A_OR,   S_LOGIC, 32'h0,         32'hABCD_0000, 5'd10, 1'b1, 1'b0};
        insts[2] = 32'h0060_5827; exps[2] = '{32'h308, A_NOR,  S_LOGIC, 32'h0000_000F, 32'h0,         5'd11, 1'b1, 1'b0};
        insts[3] = 32'h0061_6023; exps[3] = '{32'h30C, A_SUBU, S_ARITH, 32'h0000_000F, 32'hAAAA_0001, 5'd12, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if_valid = 1; id_pc = 32'h300 + 32'(4 * i); id_inst = insts[i];
            #1;
            vectors++;
            if (if_ready !== 1'b1) begin errors++; $display("FAIL b2b_if_ready_%0d: got %b want 1", i, if_ready); end
            sb.push_back(exps[i]);
            tick();
        end
        if_valid = 0;
        tick();
    endtask

    task automatic test_flush;
        exp_t x;
        if_valid = 1; id_pc = 32'h400; id_inst = 32'h3408_0001;
        tick();
        ex_ready = 0; id_pc = 32'h404; id_inst = 32'h3409_0002;
        tick();
        flush = 1; ex_ready = 1; id_pc = 32'h408; id_inst = 32'h2424_FFFF;
        ex_fw_is_load = 1; ex_fw_wr_en = 1; ex_fw_waddr = 5'd1;
        #1;
        vectors++;
        if (if_ready !== 1'b0) begin errors++; $display("FAIL flush_if_ready: got %b want 0", if_ready); end
        tick();
        vectors++;
        if ({ex_valid, stall_cnt} !== {1'b0, 4'(exp_stall)}) begin
            errors++;
            $display("FAIL flush_drop: got ex_valid=%b cnt=%0d want 0/%0d", ex_valid, stall_cnt, exp_stall);
        end
        set_idle();
        if_valid = 1; id_pc = 32'h410; id_inst = 32'hFC00_0000;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin errors++; $display("FAIL invalid_if_ready: got %b want 1", if_ready); end
        x = '{32'h410, A_NOP, S_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
        sb.push_back(x);
        tick();
        if_valid = 0;
        vectors++;
        if ({ex_inst_invalid, ex_wr_en} !== 2'b10) begin
            errors++;
            $display("FAIL invalid_flags: got inv=%b we=%b want 1/0", ex_inst_invalid, ex_wr_en);
        end
        tick();
    endtask

    task automatic test_stall_sat;
        exp_t x;
        if_valid = 1; id_pc = 32'h500; id_inst = 32'h2424_FFFF;
        ex_fw_is_load = 1; ex_fw_wr_en = 1; ex_fw_waddr = 5'd1;
        for (int i = 0; i < 18; i++) begin
            bump_stall();
            tick();
            vectors++;
            if (stall_cnt !== 4'(exp_stall)) begin errors++; $display("FAIL stall_sat_%0d: got %0d want %0d", i, stall_cnt, exp_stall); end
        end
        ex_fw_is_load = 0; ex_fw_wr_en = 0;
        x = '{32'h500, A_ADDIU, S_ARITH, 32'hAAAA_0001, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0};
        sb.push_back(x);
        tick();
        if_valid = 0;
        tick();
    endtask

    task automatic test_async_reset;
        if_valid = 1; id_pc = 32'h600; id_inst = 32'h3408_0001;
        tick();
        if_valid = 0; ex_ready = 0;
        tick();
        #2;
        rst = 0;
        #1;
        exp_stall = 0;
        vectors++;
        if ({ex_valid, ex_aluop, stall_cnt} !== {1'b0, A_NOP, 4'd0}) begin
            errors++;
            $display("FAIL async_reset: got vld=%b op=%h cnt=%0d want 0/00/0", ex_valid, ex_aluop, stall_cnt);
        end
        rst = 1;
        ex_ready = 1;
        tick();
        vectors++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", ex_valid); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0100_0000 + 32'(i);
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'hAAAA_0001;
        rf[3] = 32'h0000_000F;
        test_reset();
        test_ori();
        test_forward();
        test_load_use();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_stall_sat();
        test_async_reset();
        tick();
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d entries left want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
